// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants, decoded-op payload and the instruction decode helper for id_stage_pipe.
package id_stage_pipe_pkg;

   localparam int unsigned INST_W   = 32;
   localparam int unsigned ALUOP_W  = 8;
   localparam int unsigned ALUSEL_W = 3;

   // Primary opcodes
   localparam logic [5:0] OP_SPECIAL  = 6'b000000;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_ADDI     = 6'b001000;
   localparam logic [5:0] OP_ADDIU    = 6'b001001;
   localparam logic [5:0] OP_SLTI     = 6'b001010;
   localparam logic [5:0] OP_SLTIU    = 6'b001011;
   localparam logic [5:0] OP_ANDI     = 6'b001100;
   localparam logic [5:0] OP_ORI      = 6'b001101;
   localparam logic [5:0] OP_XORI     = 6'b001110;
   localparam logic [5:0] OP_LUI      = 6'b001111;
   localparam logic [5:0] OP_PREF     = 6'b110011;

   // SPECIAL funct codes
   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_SLLV  = 6'b000100;
   localparam logic [5:0] F_SRLV  = 6'b000110;
   localparam logic [5:0] F_SRAV  = 6'b000111;
   localparam logic [5:0] F_MOVZ  = 6'b001010;
   localparam logic [5:0] F_MOVN  = 6'b001011;
   localparam logic [5:0] F_SYNC  = 6'b001111;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   // SPECIAL2 funct codes
   localparam logic [5:0] F2_MUL = 6'b000010;
   localparam logic [5:0] F2_CLZ = 6'b100000;
   localparam logic [5:0] F2_CLO = 6'b100001;

   // ALU operation codes
   localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b00000000;
   localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b00100100;
   localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b00100101;
   localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b00100110;
   localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b00100111;
   localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b01111100;
   localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b00000010;
   localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b00000011;
   localparam logic [ALUOP_W-1:0] EXE_MOVZ_OP  = 8'b00001010;
   localparam logic [ALUOP_W-1:0] EXE_MOVN_OP  = 8'b00001011;
   localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b00010000;
   localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b00010001;
   localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b00010010;
   localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b00010011;
   localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = 8'b00101010;
   localparam logic [ALUOP_W-1:0] EXE_SLTU_OP  = 8'b00101011;
   localparam logic [ALUOP_W-1:0] EXE_ADD_OP   = 8'b00100000;
   localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = 8'b00100001;
   localparam logic [ALUOP_W-1:0] EXE_SUB_OP   = 8'b00100010;
   localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = 8'b00100011;
   localparam logic [ALUOP_W-1:0] EXE_ADDI_OP  = 8'b01010101;
   localparam logic [ALUOP_W-1:0] EXE_ADDIU_OP = 8'b01010110;
   localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b00011000;
   localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b00011001;
   localparam logic [ALUOP_W-1:0] EXE_MUL_OP   = 8'b10101001;
   localparam logic [ALUOP_W-1:0] EXE_CLZ_OP   = 8'b10110000;
   localparam logic [ALUOP_W-1:0] EXE_CLO_OP   = 8'b10110001;

   // Result-select codes
   localparam logic [ALUSEL_W-1:0] EXE_RES_NOP        = 3'b000;
   localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC      = 3'b001;
   localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT      = 3'b010;
   localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE       = 3'b011;
   localparam logic [ALUSEL_W-1:0] EXE_RES_ARITHMETIC = 3'b100;
   localparam logic [ALUSEL_W-1:0] EXE_RES_MUL        = 3'b101;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_ZX,
      IMM_SX,
      IMM_LUI,
      IMM_SHAMT
   } imm_kind_e;

   typedef struct packed {
      logic                known;
      logic [ALUOP_W-1:0]  aluop;
      logic [ALUSEL_W-1:0] alusel;
      logic                re1;
      logic                re2;
      logic                wreg;
      logic                wd_rt;
      logic                movz;
      logic                movn;
      imm_kind_e           imm;
   } dec_t;

   function automatic dec_t mk_dec(input logic [ALUOP_W-1:0] aluop, input logic [ALUSEL_W-1:0] alusel,
                                   input logic re1, input logic re2, input logic wreg,
                                   input logic wd_rt, input imm_kind_e imm);
      dec_t d;
      d.known  = 1'b1;
      d.aluop  = aluop;
      d.alusel = alusel;
      d.re1    = re1;
      d.re2    = re2;
      d.wreg   = wreg;
      d.wd_rt  = wd_rt;
      d.movz   = 1'b0;
      d.movn   = 1'b0;
      d.imm    = imm;
      return d;
   endfunction

   // Unknown encodings fall out as a NOP with known=0.
   function automatic dec_t decode(input logic [INST_W-1:0] inst);
      dec_t d;
      d = mk_dec(EXE_NOP_OP, EXE_RES_NOP, 1'b0, 1'b0, 1'b0, 1'b0, IMM_NONE);
      d.known = 1'b0;
      case (inst[31:26])
         OP_SPECIAL: begin
            case (inst[5:0])
               F_AND:   d = mk_dec(EXE_AND_OP,  EXE_RES_LOGIC, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_OR:    d = mk_dec(EXE_OR_OP,   EXE_RES_LOGIC, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_XOR:   d = mk_dec(EXE_XOR_OP,  EXE_RES_LOGIC, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_NOR:   d = mk_dec(EXE_NOR_OP,  EXE_RES_LOGIC, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_SLLV:  d = mk_dec(EXE_SLL_OP,  EXE_RES_SHIFT, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_SRLV:  d = mk_dec(EXE_SRL_OP,  EXE_RES_SHIFT, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_SRAV:  d = mk_dec(EXE_SRA_OP,  EXE_RES_SHIFT, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_SLL:   if (inst[25:21] == 5'd0)
                           d = mk_dec(EXE_SLL_OP, EXE_RES_SHIFT, 1'b0, 1'b1, 1'b1, 1'b0, IMM_SHAMT);
               F_SRL:   if (inst[25:21] == 5'd0)
                           d = mk_dec(EXE_SRL_OP, EXE_RES_SHIFT, 1'b0, 1'b1, 1'b1, 1'b0, IMM_SHAMT);
               F_SRA:   if (inst[25:21] == 5'd0)
                           d = mk_dec(EXE_SRA_OP, EXE_RES_SHIFT, 1'b0, 1'b1, 1'b1, 1'b0, IMM_SHAMT);
               F_SYNC:  d = mk_dec(EXE_NOP_OP,  EXE_RES_NOP,  1'b0, 1'b0, 1'b0, 1'b0, IMM_NONE);
               F_MFHI:  d = mk_dec(EXE_MFHI_OP, EXE_RES_MOVE, 1'b0, 1'b0, 1'b1, 1'b0, IMM_NONE);
               F_MFLO:  d = mk_dec(EXE_MFLO_OP, EXE_RES_MOVE, 1'b0, 1'b0, 1'b1, 1'b0, IMM_NONE);
               F_MTHI:  d = mk_dec(EXE_MTHI_OP, EXE_RES_NOP,  1'b1, 1'b0, 1'b0, 1'b0, IMM_NONE);
               F_MTLO:  d = mk_dec(EXE_MTLO_OP, EXE_RES_NOP,  1'b1, 1'b0, 1'b0, 1'b0, IMM_NONE);
               F_MOVN: begin
                  d = mk_dec(EXE_MOVN_OP, EXE_RES_MOVE, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
                  d.movn = 1'b1;
               end
               F_MOVZ: begin
                  d = mk_dec(EXE_MOVZ_OP, EXE_RES_MOVE, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
                  d.movz = 1'b1;
               end
               F_SLT:   d = mk_dec(EXE_SLT_OP,   EXE_RES_ARITHMETIC, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_SLTU:  d = mk_dec(EXE_SLTU_OP,  EXE_RES_ARITHMETIC, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_ADD:   d = mk_dec(EXE_ADD_OP,   EXE_RES_ARITHMETIC, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_ADDU:  d = mk_dec(EXE_ADDU_OP,  EXE_RES_ARITHMETIC, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_SUB:   d = mk_dec(EXE_SUB_OP,   EXE_RES_ARITHMETIC, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_SUBU:  d = mk_dec(EXE_SUBU_OP,  EXE_RES_ARITHMETIC, 1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               F_MULT:  d = mk_dec(EXE_MULT_OP,  EXE_RES_NOP, 1'b1, 1'b1, 1'b0, 1'b0, IMM_NONE);
               F_MULTU: d = mk_dec(EXE_MULTU_OP, EXE_RES_NOP, 1'b1, 1'b1, 1'b0, 1'b0, IMM_NONE);
               default: ;
            endcase
         end
         OP_SPECIAL2: begin
            case (inst[5:0])
               F2_CLZ:  d = mk_dec(EXE_CLZ_OP, EXE_RES_ARITHMETIC, 1'b1, 1'b0, 1'b1, 1'b0, IMM_NONE);
               F2_CLO:  d = mk_dec(EXE_CLO_OP, EXE_RES_ARITHMETIC, 1'b1, 1'b0, 1'b1, 1'b0, IMM_NONE);
               F2_MUL:  d = mk_dec(EXE_MUL_OP, EXE_RES_MUL,        1'b1, 1'b1, 1'b1, 1'b0, IMM_NONE);
               default: ;
            endcase
         end
         OP_ORI:   d = mk_dec(EXE_OR_OP,    EXE_RES_LOGIC,      1'b1, 1'b0, 1'b1, 1'b1, IMM_ZX);
         OP_ANDI:  d = mk_dec(EXE_AND_OP,   EXE_RES_LOGIC,      1'b1, 1'b0, 1'b1, 1'b1, IMM_ZX);
         OP_XORI:  d = mk_dec(EXE_XOR_OP,   EXE_RES_LOGIC,      1'b1, 1'b0, 1'b1, 1'b1, IMM_ZX);
         OP_LUI:   d = mk_dec(EXE_OR_OP,    EXE_RES_LOGIC,      1'b0, 1'b0, 1'b1, 1'b1, IMM_LUI);
         OP_ADDI:  d = mk_dec(EXE_ADDI_OP,  EXE_RES_ARITHMETIC, 1'b1, 1'b0, 1'b1, 1'b1, IMM_SX);
         OP_ADDIU: d = mk_dec(EXE_ADDIU_OP, EXE_RES_ARITHMETIC, 1'b1, 1'b0, 1'b1, 1'b1, IMM_SX);
         OP_SLTI:  d = mk_dec(EXE_SLT_OP,   EXE_RES_ARITHMETIC, 1'b1, 1'b0, 1'b1, 1'b1, IMM_SX);
         OP_SLTIU: d = mk_dec(EXE_SLTU_OP,  EXE_RES_ARITHMETIC, 1'b1, 1'b0, 1'b1, 1'b1, IMM_SX);
         OP_PREF:  d = mk_dec(EXE_NOP_OP,   EXE_RES_NOP,        1'b0, 1'b0, 1'b0, 1'b0, IMM_NONE);
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/id_stage_pipe_fwd_mux.sv
// Per-read-port operand resolver: $0 -> 0, youngest matching forwarding source, else register file.
module id_fwd_mux #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned FWD_N  = 2
) (
   input  logic                     i_en,
   input  logic [REG_AW-1:0]        i_addr,
   input  logic [DATA_W-1:0]        i_rf_rdata,
   input  logic [FWD_N-1:0]         i_fwd_wreg,
   input  logic [FWD_N*REG_AW-1:0]  i_fwd_wd,
   input  logic [FWD_N*DATA_W-1:0]  i_fwd_wdata,
   input  logic [FWD_N-1:0]         i_fwd_pend,
   output logic [DATA_W-1:0]        o_value_c,
   output logic                     o_pend_hit_c
);

   logic w_hit;

   // Lowest index hit wins; a port that is unused or reads $0 never forwards nor stalls.
   always_comb begin
      w_hit        = 1'b0;
      o_value_c    = i_rf_rdata;
      o_pend_hit_c = 1'b0;
      for (int i = 0; i < int'(FWD_N); i++) begin
         if (!w_hit && i_fwd_wreg[i] && (i_fwd_wd[i*REG_AW +: REG_AW] == i_addr)) begin
            w_hit        = 1'b1;
            o_value_c    = i_fwd_wdata[i*DATA_W +: DATA_W];
            o_pend_hit_c = i_fwd_pend[i];
         end
      end
      if (!i_en || (i_addr == '0)) begin
         o_value_c    = '0;
         o_pend_hit_c = 1'b0;
      end
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered MIPS decode stage with operand forwarding, load-use stall and valid/ready handshakes.
// Optional ID_RI_EXCP_EN adds out_excp_ri flagging undecodable instructions.
module id_stage_pipe
   import id_stage_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned FWD_N  = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_pc,
   input  logic [INST_W-1:0]        in_inst,
   output logic [REG_AW-1:0]        rf_raddr1,
   output logic [REG_AW-1:0]        rf_raddr2,
   input  logic [DATA_W-1:0]        rf_rdata1,
   input  logic [DATA_W-1:0]        rf_rdata2,
   input  logic [FWD_N-1:0]         fwd_wreg,
   input  logic [FWD_N*REG_AW-1:0]  fwd_wd,
   input  logic [FWD_N*DATA_W-1:0]  fwd_wdata,
   input  logic [FWD_N-1:0]         fwd_pend,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_pc,
   output logic [ALUOP_W-1:0]       out_aluop,
   output logic [ALUSEL_W-1:0]      out_alusel,
   output logic [DATA_W-1:0]        out_reg1,
   output logic [DATA_W-1:0]        out_reg2,
   output logic [REG_AW-1:0]        out_wd,
   output logic                     out_wreg,
   output logic [CNT_W-1:0]         stall_cnt
`ifdef ID_RI_EXCP_EN
   ,output logic                    out_excp_ri
`endif
);

   dec_t                w_dec;
   logic [DATA_W-1:0]   w_val1;
   logic [DATA_W-1:0]   w_val2;
   logic                w_pend1;
   logic                w_pend2;
   logic                w_hazard;
   logic                w_accept;
   logic [DATA_W-1:0]   w_imm;
   logic [DATA_W-1:0]   w_reg1;
   logic [DATA_W-1:0]   w_reg2;
   logic [REG_AW-1:0]   w_wd;
   logic                w_wreg;

   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_pc;
   logic [ALUOP_W-1:0]  r_out_aluop;
   logic [ALUSEL_W-1:0] r_out_alusel;
   logic [DATA_W-1:0]   r_out_reg1;
   logic [DATA_W-1:0]   r_out_reg2;
   logic [REG_AW-1:0]   r_out_wd;
   logic                r_out_wreg;
   logic [CNT_W-1:0]    r_stall_cnt;

   assign w_dec     = decode(in_inst);
   assign rf_raddr1 = REG_AW'(in_inst[25:21]);
   assign rf_raddr2 = REG_AW'(in_inst[20:16]);

   id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N)) u_fwd_rs (
      .i_en         (w_dec.re1),
      .i_addr       (rf_raddr1),
      .i_rf_rdata   (rf_rdata1),
      .i_fwd_wreg   (fwd_wreg),
      .i_fwd_wd     (fwd_wd),
      .i_fwd_wdata  (fwd_wdata),
      .i_fwd_pend   (fwd_pend),
      .o_value_c    (w_val1),
      .o_pend_hit_c (w_pend1)
   );

   id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N)) u_fwd_rt (
      .i_en         (w_dec.re2),
      .i_addr       (rf_raddr2),
      .i_rf_rdata   (rf_rdata2),
      .i_fwd_wreg   (fwd_wreg),
      .i_fwd_wd     (fwd_wd),
      .i_fwd_wdata  (fwd_wdata),
      .i_fwd_pend   (fwd_pend),
      .o_value_c    (w_val2),
      .o_pend_hit_c (w_pend2)
   );

   assign w_hazard = w_pend1 | w_pend2;
   assign in_ready = rst & ~flush & ~w_hazard & (~r_out_valid | out_ready);
   assign w_accept = in_valid & in_ready;

   // Immediate / shift-amount operand selection
   always_comb begin
      w_imm = '0;
      case (w_dec.imm)
         IMM_ZX:    w_imm = DATA_W'(in_inst[15:0]);
         IMM_SX:    w_imm = {{(DATA_W-16){in_inst[15]}}, in_inst[15:0]};
         IMM_LUI:   w_imm = DATA_W'({in_inst[15:0], 16'h0000});
         IMM_SHAMT: w_imm = DATA_W'(in_inst[10:6]);
         default:   w_imm = '0;
      endcase
   end

   assign w_reg1 = (w_dec.imm == IMM_SHAMT) ? w_imm : w_val1;
   assign w_reg2 = w_dec.re2 ? w_val2 : ((w_dec.imm == IMM_SHAMT) ? '0 : w_imm);
   assign w_wd   = !w_dec.wreg ? '0 : (w_dec.wd_rt ? REG_AW'(in_inst[20:16]) : REG_AW'(in_inst[15:11]));

   // Conditional moves resolve their write enable from the forwarded rt value.
   assign w_wreg = w_dec.known & w_dec.wreg
                 & ~(w_dec.movz & (w_reg2 != '0))
                 & ~(w_dec.movn & (w_reg2 == '0));

`ifdef ID_RI_EXCP_EN
   logic r_out_excp_ri;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_out_valid  <= 1'b0;
         r_out_pc     <= '0;
         r_out_aluop  <= EXE_NOP_OP;
         r_out_alusel <= EXE_RES_NOP;
         r_out_reg1   <= '0;
         r_out_reg2   <= '0;
         r_out_wd     <= '0;
         r_out_wreg   <= 1'b0;
`ifdef ID_RI_EXCP_EN
         r_out_excp_ri <= 1'b0;
`endif
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         r_out_pc     <= in_pc;
         r_out_aluop  <= w_dec.aluop;
         r_out_alusel <= w_dec.alusel;
         r_out_reg1   <= w_reg1;
         r_out_reg2   <= w_reg2;
         r_out_wd     <= w_wd;
         r_out_wreg   <= w_wreg;
`ifdef ID_RI_EXCP_EN
         r_out_excp_ri <= ~w_dec.known;
`endif
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Saturating count of cycles an offered instruction is held back by a hazard
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (in_valid && w_hazard && !flush && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign out_valid  = r_out_valid;
   assign out_pc     = r_out_pc;
   assign out_aluop  = r_out_aluop;
   assign out_alusel = r_out_alusel;
   assign out_reg1   = r_out_reg1;
   assign out_reg2   = r_out_reg2;
   assign out_wd     = r_out_wd;
   assign out_wreg   = r_out_wreg;
   assign stall_cnt  = r_stall_cnt;
`ifdef ID_RI_EXCP_EN
   assign out_excp_ri = r_out_excp_ri;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe (default parameters).
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic [1:0]  fwd_wreg;
   logic [9:0]  fwd_wd;
   logic [63:0] fwd_wdata;
   logic [1:0]  fwd_pend;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [7:0]  out_aluop;
   logic [2:0]  out_alusel;
   logic [31:0] out_reg1, out_reg2;
   logic [4:0]  out_wd;
   logic        out_wreg;
   logic [15:0] stall_cnt;
`ifdef ID_RI_EXCP_EN
   logic        out_excp_ri;
`endif

   logic [31:0] regs [32];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   id_stage_pipe dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata), .fwd_pend(fwd_pend),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_aluop(out_aluop), .out_alusel(out_alusel),
      .out_reg1(out_reg1), .out_reg2(out_reg2), .out_wd(out_wd), .out_wreg(out_wreg),
      .stall_cnt(stall_cnt)
`ifdef ID_RI_EXCP_EN
      , .out_excp_ri(out_excp_ri)
`endif
   );

   function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
      return {op, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
      in_valid = 1'b1; in_inst = inst; in_pc = pc;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic fwd_idle();
      fwd_wreg = 2'b00; fwd_wd = '0; fwd_wdata = '0; fwd_pend = 2'b00;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_aluop !== 8'h00) begin bad++; $display("FAIL reset_aluop got=%h exp=00", out_aluop); end
      total++; if (out_alusel !== 3'd0) begin bad++; $display("FAIL reset_alusel got=%0d exp=0", out_alusel); end
      total++; if (out_reg1 !== 32'd0 || out_reg2 !== 32'd0 || out_pc !== 32'd0) begin bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", out_reg1, out_reg2, out_pc); end
      total++; if (out_wd !== 5'd0 || out_wreg !== 1'b0) begin bad++; $display("FAIL reset_wd got=%0d/%b exp=0/0", out_wd, out_wreg); end
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_ori();
      in_valid = 1'b1; in_inst = enc_i(6'b001101, 5'd0, 5'd1, 16'h1234); in_pc = 32'h100;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ori_in_ready got=%b exp=1", in_ready); end
      tick(); in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ori_valid got=%b exp=1", out_valid); end
      total++; if (out_reg1 !== 32'd0 || out_reg2 !== 32'h1234) begin bad++; $display("FAIL ori_regs got=%h/%h exp=0/1234", out_reg1, out_reg2); end
      total++; if (out_wd !== 5'd1 || out_wreg !== 1'b1) begin bad++; $display("FAIL ori_wd got=%0d/%b exp=1/1", out_wd, out_wreg); end
      total++; if (out_aluop !== 8'h25 || out_alusel !== 3'd1 || out_pc !== 32'h100) begin bad++; $display("FAIL ori_op got=%h/%0d/%h exp=25/1/100", out_aluop, out_alusel, out_pc); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ori_bubble got=%b exp=0", out_valid); end
   endtask

   task automatic test_forwarding();
      fwd_wreg = 2'b11; fwd_wd = {5'd1, 5'd1}; fwd_wdata = {32'd9, 32'd5};
      issue(enc_r(6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001), 32'h104);
      total++; if (out_reg1 !== 32'd5 || out_reg2 !== 32'd200) begin bad++; $display("FAIL fwd_youngest got=%0d/%0d exp=5/200", out_reg1, out_reg2); end
      total++; if (out_aluop !== 8'h21 || out_alusel !== 3'd4 || out_wd !== 5'd3) begin bad++; $display("FAIL fwd_addu_op got=%h/%0d/%0d exp=21/4/3", out_aluop, out_alusel, out_wd); end
      fwd_wreg = 2'b10;
      issue(enc_r(6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001), 32'h108);
      total++; if (out_reg1 !== 32'd9) begin bad++; $display("FAIL fwd_older got=%0d exp=9", out_reg1); end
      fwd_wreg = 2'b00;
      issue(enc_r(6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001), 32'h10c);
      total++; if (out_reg1 !== 32'd100) begin bad++; $display("FAIL fwd_nowreg got=%0d exp=100", out_reg1); end
      fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd0}; fwd_wdata = {32'd0, 32'hDEAD};
      issue(enc_r(6'b0, 5'd0, 5'd2, 5'd5, 5'd0, 6'b100001), 32'h110);
      total++; if (out_reg1 !== 32'd0 || out_reg2 !== 32'd200) begin bad++; $display("FAIL fwd_zero_reg got=%h/%0d exp=0/200", out_reg1, out_reg2); end
      fwd_idle();
      tick();
   endtask

   task automatic test_immediates();
      issue(enc_i(6'b001111, 5'd0, 5'd7, 16'hABCD), 32'h200);
      total++; if (out_reg1 !== 32'd0 || out_reg2 !== 32'hABCD0000 || out_wd !== 5'd7) begin bad++; $display("FAIL lui got=%h/%h/%0d exp=0/abcd0000/7", out_reg1, out_reg2, out_wd); end
      issue(enc_i(6'b001000, 5'd1, 5'd8, 16'hFFF0), 32'h204);
      total++; if (out_reg1 !== 32'd100 || out_reg2 !== 32'hFFFFFFF0) begin bad++; $display("FAIL addi_sext got=%h/%h exp=64/fffffff0", out_reg1, out_reg2); end
      total++; if (out_aluop !== 8'h55 || out_wd !== 5'd8 || out_wreg !== 1'b1) begin bad++; $display("FAIL addi_op got=%h/%0d/%b exp=55/8/1", out_aluop, out_wd, out_wreg); end
      issue(enc_r(6'b0, 5'd0, 5'd2, 5'd9, 5'd4, 6'b000000), 32'h208);
      total++; if (out_reg1 !== 32'd4 || out_reg2 !== 32'd200 || out_wd !== 5'd9) begin bad++; $display("FAIL sll got=%0d/%0d/%0d exp=4/200/9", out_reg1, out_reg2, out_wd); end
      total++; if (out_aluop !== 8'h7C || out_alusel !== 3'd2) begin bad++; $display("FAIL sll_op got=%h/%0d exp=7c/2", out_aluop, out_alusel); end
      tick();
   endtask

   task automatic test_hazard();
      fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd2}; fwd_wdata = {32'd0, 32'd33}; fwd_pend = 2'b01;
      in_valid = 1'b1; in_inst = enc_r(6'b0, 5'd2, 5'd2, 5'd4, 5'd0, 6'b100010); in_pc = 32'h300;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL haz_ready0 got=%b exp=0", in_ready); end
      tick();
      total++; if (in_ready !== 1'b0 || stall_cnt !== 16'd1) begin bad++; $display("FAIL haz_cyc1 got=%b/%0d exp=0/1", in_ready, stall_cnt); end
      tick();
      total++; if (stall_cnt !== 16'd2 || out_valid !== 1'b0) begin bad++; $display("FAIL haz_cyc2 got=%0d/%b exp=2/0", stall_cnt, out_valid); end
      fwd_pend = 2'b00;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL haz_release got=%b exp=1", in_ready); end
      tick(); in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_reg1 !== 32'd33 || out_reg2 !== 32'd33) begin bad++; $display("FAIL haz_issue got=%b/%0d/%0d exp=1/33/33", out_valid, out_reg1, out_reg2); end
      total++; if (out_aluop !== 8'h22 || out_wd !== 5'd4 || stall_cnt !== 16'd2) begin bad++; $display("FAIL haz_op got=%h/%0d/%0d exp=22/4/2", out_aluop, out_wd, stall_cnt); end
      // older pending source shadowed by a youngest non-pending hit, and an op that reads nothing
      fwd_wreg = 2'b11; fwd_wd = {5'd2, 5'd2}; fwd_wdata = {32'd77, 32'd11}; fwd_pend = 2'b10;
      in_valid = 1'b1; in_inst = enc_r(6'b0, 5'd2, 5'd0, 5'd4, 5'd0, 6'b100001);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL haz_shadow got=%b exp=1", in_ready); end
      fwd_pend = 2'b01; in_inst = enc_i(6'b001111, 5'd0, 5'd2, 16'h0001);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL haz_unused got=%b exp=1", in_ready); end
      in_valid = 1'b0; fwd_idle();
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      issue(enc_i(6'b001101, 5'd0, 5'd1, 16'h0011), 32'h400);
      total++; if (out_valid !== 1'b1 || out_reg2 !== 32'h11) begin bad++; $display("FAIL bp_load got=%b/%h exp=1/11", out_valid, out_reg2); end
      in_valid = 1'b1; in_inst = enc_i(6'b001101, 5'd0, 5'd2, 16'h0022); in_pc = 32'h404;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, in_ready); end
         tick();
         total++; if (out_valid !== 1'b1 || out_reg2 !== 32'h11 || out_wd !== 5'd1 || out_pc !== 32'h400) begin bad++; $display("FAIL bp_frozen cyc=%0d got=%b/%h/%0d exp=1/11/1", c, out_valid, out_reg2, out_wd); end
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
      tick(); in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_reg2 !== 32'h22 || out_wd !== 5'd2) begin bad++; $display("FAIL bp_next got=%b/%h/%0d exp=1/22/2", out_valid, out_reg2, out_wd); end
      tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      issue(enc_i(6'b001101, 5'd0, 5'd1, 16'h0011), 32'h500);
      flush = 1'b1; out_ready = 1'b1;
      in_valid = 1'b1; in_inst = enc_i(6'b001101, 5'd0, 5'd2, 16'h0022);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_kill got=%b exp=0", out_valid); end
      flush = 1'b0; in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_noaccept got=%b exp=0", out_valid); end
   endtask

   task automatic test_movz_invalid();
      fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd6}; fwd_wdata = {32'd0, 32'd0};
      issue(enc_r(6'b0, 5'd1, 5'd6, 5'd10, 5'd0, 6'b001010), 32'h600);
      total++; if (out_wreg !== 1'b1 || out_reg2 !== 32'd0 || out_reg1 !== 32'd100) begin bad++; $display("FAIL movz_zero got=%b/%0d/%0d exp=1/0/100", out_wreg, out_reg2, out_reg1); end
      total++; if (out_aluop !== 8'h0A || out_alusel !== 3'd3 || out_wd !== 5'd10) begin bad++; $display("FAIL movz_op got=%h/%0d/%0d exp=0a/3/10", out_aluop, out_alusel, out_wd); end
      fwd_wdata = {32'd0, 32'd7};
      issue(enc_r(6'b0, 5'd1, 5'd6, 5'd10, 5'd0, 6'b001010), 32'h604);
      total++; if (out_wreg !== 1'b0 || out_reg2 !== 32'd7) begin bad++; $display("FAIL movz_nz got=%b/%0d exp=0/7", out_wreg, out_reg2); end
      issue(enc_r(6'b0, 5'd1, 5'd6, 5'd10, 5'd0, 6'b001011), 32'h608);
      total++; if (out_wreg !== 1'b1) begin bad++; $display("FAIL movn_nz got=%b exp=1", out_wreg); end
      fwd_idle();
      issue(32'hFC000000, 32'h60c);
      total++; if (out_valid !== 1'b1 || out_wreg !== 1'b0 || out_aluop !== 8'h00 || out_alusel !== 3'd0) begin bad++; $display("FAIL invalid_nop got=%b/%b/%h/%0d exp=1/0/00/0", out_valid, out_wreg, out_aluop, out_alusel); end
`ifdef ID_RI_EXCP_EN
      total++; if (out_excp_ri !== 1'b1) begin bad++; $display("FAIL invalid_excp got=%b exp=1", out_excp_ri); end
`endif
      tick();
   endtask

   task automatic test_reset_mid_stall();
      out_ready = 1'b0;
      issue(enc_i(6'b001101, 5'd0, 5'd1, 16'h0055), 32'h700);
      fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd2}; fwd_pend = 2'b01;
      in_valid = 1'b1; in_inst = enc_r(6'b0, 5'd2, 5'd2, 5'd4, 5'd0, 6'b100010);
      tick();
      total++; if (stall_cnt !== 16'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL rst_stall_pre got=%0d/%b exp=3/1", stall_cnt, out_valid); end
      rst = 1'b0;
      tick();
      total++; if (stall_cnt !== 16'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_stall_post got=%0d/%b exp=0/0", stall_cnt, out_valid); end
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fwd_idle();
      tick();
   endtask

   initial begin
      for (int r = 0; r < 32; r++) regs[r] = 32'd0;
      regs[1] = 32'd100;
      regs[2] = 32'd200;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b1;
      fwd_idle();
      test_reset();
      test_ori();
      test_forwarding();
      test_immediates();
      test_hazard();
      test_backpressure();
      test_flush();
      test_movz_invalid();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
